// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared types and constants for the SCCB target
// Contents: target state enum, R/W flag position, device-ID compare mask,
//           and the ID match helper used by the ID phase.
package sccb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID,
        ST_SUB,
        ST_WDATA,
        ST_RDATA,
        ST_ACK,
        ST_IGNORE
    } state_e;

    // Bit 0 of the ID byte selects direction: 0 = write, 1 = read.
    localparam int unsigned RW_BIT = 0;

    // Only bits [7:1] of the ID byte identify the device.
    localparam logic [7:0] ID_MASK = 8'hFE;

    function automatic logic id_match(input logic [7:0] rx, input logic [7:0] dev);
        return ((rx ^ dev) & ID_MASK) == 8'h00;
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// rtl/sccb_line_sync.sv - SIOC/SIOD synchronizer and bus event detector
// Ports:
//   clk_i, rst_i     system clock, async active-low reset
//   sioc_i, siod_i   raw bus lines
//   sioc_rise_o      one-clk pulse on synchronized SIOC rising edge
//   sioc_fall_o      one-clk pulse on synchronized SIOC falling edge
//   start_det_o      SIOD fell while SIOC was stable high
//   stop_det_o       SIOD rose while SIOC high
//   siod_o           synchronized SIOD level (bit sampling)
module sccb_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sioc_i,
    input  logic siod_i,
    output logic sioc_rise_o,
    output logic sioc_fall_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic siod_o
);

    logic [SYNC_STAGES-1:0] sioc_sync_q;
    logic [SYNC_STAGES-1:0] siod_sync_q;
    logic                   sioc_hist_q;
    logic                   siod_hist_q;
    logic                   sioc_s;
    logic                   siod_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge
    // that looks like a start condition.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sioc_sync_q <= '1;
            siod_sync_q <= '1;
            sioc_hist_q <= 1'b1;
            siod_hist_q <= 1'b1;
        end else begin
            sioc_sync_q <= {sioc_sync_q[SYNC_STAGES-2:0], sioc_i};
            siod_sync_q <= {siod_sync_q[SYNC_STAGES-2:0], siod_i};
            sioc_hist_q <= sioc_s;
            siod_hist_q <= siod_s;
        end
    end

    assign sioc_s      = sioc_sync_q[SYNC_STAGES-1];
    assign siod_s      = siod_sync_q[SYNC_STAGES-1];
    assign sioc_rise_o = sioc_s & ~sioc_hist_q;
    assign sioc_fall_o = ~sioc_s & sioc_hist_q;
    assign start_det_o = sioc_s & sioc_hist_q & siod_hist_q & ~siod_s;
    assign stop_det_o  = sioc_s & ~siod_hist_q & siod_s;
    assign siod_o      = siod_s;

endmodule

// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - SCCB (I2C-compatible) target with register port
// Ports:
//   clk_i, rst_i     system clock (>= 16x SIOC), async active-low reset
//   sioc_i, siod_i   bus lines from the pads
//   siod_pull_o      1 = pull SIOD low, 0 = release
//   reg_addr_o       register pointer (kept across stop for write+read)
//   reg_wdata_o      write data, valid with reg_we_o
//   reg_we_o         one-clk write strobe
//   reg_rd_o         one-clk read request for reg_addr_o
//   reg_rdata_i      read data, latched the clk after reg_rd_o
//   busy_o           transaction in progress (start .. stop)
//   nack_o           master NACKed the last read byte
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [7:0]  DEV_ID      = 8'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sioc_i,
    input  logic       siod_i,
    output logic       siod_pull_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_rd_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o,
    output logic       nack_o
);

    logic sioc_rise, sioc_fall, start_det, stop_det, siod_s;

    sccb_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sioc_i      (sioc_i),
        .siod_i      (siod_i),
        .sioc_rise_o (sioc_rise),
        .sioc_fall_o (sioc_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det),
        .siod_o      (siod_s)
    );

    state_e     state_q, state_d;
    state_e     ack_next_q, ack_next_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       pull_q, pull_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       rd_q, rd_d;
    logic       ld_q, ld_d;
    logic       busy_q, busy_d;
    logic       nack_q, nack_d;
    logic [7:0] rx_byte;

    assign rx_byte = {shift_q[6:0], siod_s};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            ack_next_q <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 4'd0;
            pull_q     <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            ld_q       <= 1'b0;
            busy_q     <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_next_q <= ack_next_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            pull_q     <= pull_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            ld_q       <= ld_d;
            busy_q     <= busy_d;
            nack_q     <= nack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_next_d = ack_next_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        pull_d     = pull_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        rd_d       = 1'b0;
        ld_d       = rd_q;
        busy_d     = busy_q;
        nack_d     = nack_q;

        // Read data arrives one clk after the request; pointer advances
        // one clk after a write strobe so the strobe sees the old address.
        if (ld_q) begin
            shift_d = reg_rdata_i;
        end
        if (we_q) begin
            addr_d = addr_q + 8'd1;
        end

        if (start_det) begin
            state_d   = ST_ID;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b1;
            nack_d    = 1'b0;
            pull_d    = 1'b0;
            ld_d      = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            pull_d  = 1'b0;
            ld_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ID, ST_SUB, ST_WDATA: begin
                    if (sioc_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            state_d   = ST_ACK;
                            if (state_q == ST_ID) begin
                                if (!id_match(rx_byte, DEV_ID)) begin
                                    state_d = ST_IGNORE;
                                end else if (rx_byte[RW_BIT]) begin
                                    ack_next_d = ST_RDATA;
                                    rd_d       = 1'b1;
                                end else begin
                                    ack_next_d = ST_SUB;
                                end
                            end else if (state_q == ST_SUB) begin
                                addr_d     = rx_byte;
                                ack_next_d = ST_WDATA;
                            end else begin
                                wdata_d    = rx_byte;
                                we_d       = 1'b1;
                                ack_next_d = ST_WDATA;
                            end
                        end
                    end
                end
                // bit_cnt 0: waiting for the fall after bit 8 to assert ACK;
                // bit_cnt 1: ACK held, next fall ends the ACK slot.
                ST_ACK: begin
                    if (sioc_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            pull_d    = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d   = ack_next_q;
                            bit_cnt_d = 4'd0;
                            pull_d    = 1'b0;
                            // Read data MSB goes out on the same edge that ends ACK.
                            if (ack_next_q == ST_RDATA) begin
                                pull_d    = ~shift_q[7];
                                shift_d   = {shift_q[6:0], 1'b0};
                                bit_cnt_d = 4'd1;
                            end
                        end
                    end
                end
                // bit_cnt counts bits driven; 9 means waiting for master ACK.
                ST_RDATA: begin
                    if (sioc_fall) begin
                        if (bit_cnt_q < 4'd8) begin
                            pull_d    = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else if (bit_cnt_q == 4'd8) begin
                            pull_d    = 1'b0;
                            bit_cnt_d = 4'd9;
                        end
                    end else if (sioc_rise && bit_cnt_q == 4'd9) begin
                        nack_d    = siod_s;
                        addr_d    = addr_q + 8'd1;
                        bit_cnt_d = 4'd0;
                        if (siod_s) begin
                            state_d = ST_IGNORE;
                        end else begin
                            rd_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign siod_pull_o = pull_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign reg_rd_o    = rd_q;
    assign busy_o      = busy_q;
    assign nack_o      = nack_q;

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- Synthesizable SCCB (I2C-compatible) target, i.e. the responder for the team's SCCB master controller.
- Emulates an OmniVision camera register bus for bench and board loopback. Camera-side logic can also expose its own register file through it.
- Oversamples SIOC/SIOD on the system clock and decodes start, ID, sub-address and data phases. It ACKs by pulling SIOD low and serves reads through a simple register-port handshake.

Parameters:
- DEV_ID, 8'h42, write device ID. Bits [7:1] are compared; bit 0 is the R/W flag (0 = write, 1 = read).
- SYNC_STAGES, 2, synchronizer depth on sioc_i/siod_i (minimum 2).

Ports:
- clk_i  in  1  system clock; must be at least 16x the SIOC frequency.
- rst_i  in  1  reset; asynchronous assert, active-low.
- sioc_i  in  1  SIOC line from the master.
- siod_i  in  1  SIOD line as seen on the pad.
- siod_pull_o  out  1  1 = drive SIOD low; 0 = release (external pull-up).
- reg_addr_o  out  8  current register pointer.
- reg_wdata_o  out  8  write data; valid while reg_we_o = 1.
- reg_we_o  out  1  one-clk write strobe.
- reg_rd_o  out  1  one-clk read request for reg_addr_o.
- reg_rdata_i  in  8  read data; sampled the clk after reg_rd_o.
- busy_o  out  1  1 from start condition until stop condition.
- nack_o  out  1  master NACKed the last read byte (sticky until next start).

Behaviour:
- Reset (async, rst_i = 0): state IDLE, siod_pull_o = 0, reg_addr_o = 0, reg_wdata_o = 0, reg_we_o = 0, reg_rd_o = 0, busy_o = 0, nack_o = 0, bit counter = 0.
  - Reset asserted mid-transaction releases SIOD in the same cycle.
- Sync: sioc_i/siod_i pass through SYNC_STAGES flops, plus one history flop each for edge detection. All decisions use the synchronized values.
- Start: sSIOD falls while sSIOC = 1 and sSIOC is stable high.
  - Valid in any state, including mid-byte (repeated start).
  - Effect: go to ID, clear bit counter, busy_o = 1, nack_o = 0, siod_pull_o = 0.
- Stop: sSIOD rises while sSIOC = 1.
  - Valid in any state.
  - Effect: go to IDLE, busy_o = 0, siod_pull_o = 0.
  - reg_addr_o is retained; this is what makes 2-phase write + read work.
- Sampling and driving:
  - Bits are sampled on the sSIOC rising edge, MSB first.
  - siod_pull_o changes only on the sSIOC falling edge, or on start/stop/reset.
- States:
  - IDLE: wait for start.
  - ID: shift 8 bits.
    - [7:1] != DEV_ID[7:1] -> IGNORE (no ACK).
    - Match with bit0 = 0 -> ACK, then SUB.
    - Match with bit0 = 1 -> ACK, then RDATA. Pulse reg_rd_o 1 clk after the 8th rising edge and latch reg_rdata_i the following clk.
  - SUB: shift 8 bits -> reg_addr_o loaded on the 8th rising edge; ACK, then WDATA.
  - WDATA: shift 8 bits.
    - On the 8th rising edge: reg_wdata_o = byte and reg_we_o pulses for 1 clk.
    - reg_addr_o increments the clk after the strobe, wrapping 8'hFF -> 8'h00.
    - ACK, then WDATA again (burst write).
  - ACK (shared sub-phase after any accepted byte):
    - Assert siod_pull_o on the falling edge after the 8th bit.
    - Hold through the 9th SIOC high.
    - Release on the next falling edge, unless RDATA immediately drives a 0 bit.
  - RDATA:
    - On each falling edge, siod_pull_o = ~shift[7], then shift left. This covers 8 bits.
    - On the falling edge after bit 0, release the line.
    - On the 9th rising edge, sample the master ACK into nack_o.
    - ACK from master (0) -> increment reg_addr_o, issue reg_rd_o, continue RDATA.
    - NACK (1) -> increment reg_addr_o, go to IGNORE.
  - IGNORE: SIOD released; wait for start or stop.
- Simultaneous events: start/stop detection has priority over bit sampling in the same clk. A stop mid-byte discards the partial byte (no reg_we_o).
- SIOD must change only while SIOC is low; any other change is treated as start/stop per the rules above.

Decomposition:
- Package sccb_pkg: state enum (IDLE, ID, SUB, WDATA, RDATA, ACK, IGNORE), the R/W bit position, and the ID-mask constant.
- One sub-module: sccb_line_sync. It holds the synchronizer and edge detector and outputs sioc_rise, sioc_fall, start_det, stop_det and sampled siod. It is reused for a future multi-target bench.

Test Plan:
1. 3-phase write ID 0x42, sub 0x12, data 0x80 then stop.
   - Master sees 3 ACKs.
   - reg_we_o pulses once with reg_addr_o = 0x12, reg_wdata_o = 0x80.
   - Afterwards reg_addr_o = 0x13 and busy_o = 0.
2. 2-phase write 0x42/0x0A, stop, start, ID 0x43; reg_rdata_i = 0x76; master NACK, stop.
   - reg_rd_o pulses once with reg_addr_o = 0x0A.
   - Master samples 0x76.
   - nack_o = 1; afterwards reg_addr_o = 0x0B.
3. Wrong ID 0x60.
   - No ACK (siod_pull_o stays 0 for the whole transaction).
   - No reg_we_o or reg_rd_o.
   - Returns to IDLE on stop.
4. Burst write at sub 0xFF with data 0x11, 0x22.
   - Writes to 0xFF then 0x00; reg_addr_o ends at 0x01.
5. Repeated start after the 4th data bit of a write, then a full write 0x42/0x05/0x5A.
   - No strobe for the aborted byte.
   - Exactly one reg_we_o, with addr 0x05 and data 0x5A.
6. rst_i low while the target is driving ACK or a read 0 bit.
   - siod_pull_o = 0 in the same cycle.
   - All outputs at reset values; recovers on the next start.
